miter_monitor: RTL and testbench

Downstream checker for the equivalence miter: consumes the two candidate outputs `y_1`/`y_2` of the paired design instances and turns the per-cycle equality assertion into a bounded, observable simulation/emulation verdict. It sequences a warm-up window, compares the outputs for a fixed number of cycles, and counts mismatches. It also captures the first failing cycle and its difference vector, then reports pass or fail for the harness to read.

---
 rtl/miter_pkg.sv | 17 +
 rtl/miter_sat_counter.sv | 27 ++
 rtl/miter_monitor.sv | 135 +++++++++++++
 tb/tb_miter_monitor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miter_pkg.sv
// Shared types and constants for the equivalence-miter run monitor.
`timescale 1ns/1ps
package miter_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;
    localparam logic [CNT_W-1:0] CNT_ONE = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_CHECK  = 3'd2,
        ST_PASS   = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

endpackage

// File: rtl/miter_sat_counter.sv
// Mismatch counter: synchronous clear, increment, holds at CNT_MAX.
`timescale 1ns/1ps
module miter_sat_counter
    import miter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/miter_monitor.sv
// Run sequencer and verdict for the y_1/y_2 equivalence miter.
// Define MITER_STOP_ON_FAIL_EN to end the run on the first recorded mismatch.
`timescale 1ns/1ps
module miter_monitor
    import miter_pkg::*;
#(
    parameter int WIDTH      = 91,
    parameter int WARMUP     = 2,
    parameter int MAX_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] y_1,
    input  logic [WIDTH-1:0] y_2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] first_fail_cycle,
    output logic [WIDTH-1:0] first_diff,
    output state_t           debug_state
);

`ifdef MITER_STOP_ON_FAIL_EN
    localparam bit LP_STOP_ON_FAIL = 1'b1;
`else
    localparam bit LP_STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LP_WARM_LAST = CNT_W'((WARMUP > 0) ? (WARMUP - 1) : 0);
    localparam logic [CNT_W-1:0] LP_CHK_LAST  = CNT_W'(MAX_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] w_cycle_next;
    logic [CNT_W-1:0] r_ffc;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] w_count;
    logic [WIDTH-1:0] w_diff;
    logic             w_mismatch;
    logic             w_can_start;
    logic             w_run_start;
    logic             w_record;
    logic             w_first;

    assign w_diff      = y_1 ^ y_2;
    assign w_mismatch  = |w_diff;
    assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_PASS) || (r_state == ST_FAIL);
    assign w_run_start = start && !abort && w_can_start;
    assign w_record    = (r_state == ST_CHECK) && w_mismatch && !abort;
    // Count never wraps back to zero, so zero means "no mismatch yet this run".
    assign w_first     = w_record && (w_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cycle <= '0;
        end else begin
            r_state <= w_next;
            r_cycle <= w_cycle_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cycle_next = r_cycle;
        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start) begin
                        w_next       = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;
                        w_cycle_next = '0;
                    end
                end
                ST_WARMUP: begin
                    if (r_cycle == LP_WARM_LAST) begin
                        w_next       = ST_CHECK;
                        w_cycle_next = '0;
                    end else begin
                        w_cycle_next = r_cycle + CNT_ONE;
                    end
                end
                ST_CHECK: begin
                    w_cycle_next = r_cycle + CNT_ONE;
                    if (LP_STOP_ON_FAIL && w_mismatch) begin
                        w_next = ST_FAIL;
                    end else if (r_cycle == LP_CHK_LAST) begin
                        // The last compared cycle's own mismatch must count too.
                        w_next = ((w_count == '0) && !w_mismatch) ? ST_PASS : ST_FAIL;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ffc  <= '0;
            r_diff <= '0;
        end else if (w_run_start) begin
            r_ffc  <= '0;
            r_diff <= '0;
        end else if (w_first) begin
            r_ffc  <= r_cycle;
            r_diff <= w_diff;
        end
    end

    miter_sat_counter u_mismatch_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_run_start),
        .i_inc   (w_record),
        .o_count (w_count)
    );

    assign busy             = (r_state == ST_WARMUP) || (r_state == ST_CHECK);
    assign pass             = (r_state == ST_PASS);
    assign fail             = (r_state == ST_FAIL);
    assign done             = pass | fail;
    assign mismatch_count   = w_count;
    assign first_fail_cycle = r_ffc;
    assign first_diff       = r_diff;
    assign debug_state      = r_state;

endmodule

// File: tb/tb_miter_monitor.sv
// Directed bench for miter_monitor with a run-age reference model and per-cycle compare.
`timescale 1ns/1ps
module tb_miter_monitor;
    import miter_pkg::*;

    localparam int WIDTH      = 91;
    localparam int WARMUP     = 2;
    localparam int MAX_CYCLES = 8;
    localparam int RUN_EDGES  = WARMUP + MAX_CYCLES;

`ifdef MITER_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] y_1   = '0;
    logic [WIDTH-1:0] y_2   = '0;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [15:0]      mismatch_count;
    logic [15:0]      first_fail_cycle;
    logic [WIDTH-1:0] first_diff;
    state_t           debug_state;

    always #5 clk = ~clk;

    miter_monitor #(
        .WIDTH      (WIDTH),
        .WARMUP     (WARMUP),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .y_1              (y_1),
        .y_2              (y_2),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail             (fail),
        .mismatch_count   (mismatch_count),
        .first_fail_cycle (first_fail_cycle),
        .first_diff       (first_diff),
        .debug_state      (debug_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A run is tracked by its age in edges since the start edge; edges past
    // the warm-up are compared, the MAX_CYCLES-th compared edge gives the verdict.
    logic             m_active;
    int               m_age;
    int               m_cnt;
    logic [15:0]      m_ffc;
    logic [WIDTH-1:0] m_diff;
    logic             m_pass;
    logic             m_fail;

    always @(posedge clk or negedge rst_n) begin : model
        int   age;
        int   idx;
        int   cnt;
        logic mism;
        if (!rst_n) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_cnt    <= 0;
            m_ffc    <= '0;
            m_diff   <= '0;
            m_pass   <= 1'b0;
            m_fail   <= 1'b0;
        end else if (abort) begin
            m_active <= 1'b0;
            m_pass   <= 1'b0;
            m_fail   <= 1'b0;
        end else if (start && !m_active) begin
            m_active <= 1'b1;
            m_age    <= 0;
            m_cnt    <= 0;
            m_ffc    <= '0;
            m_diff   <= '0;
            m_pass   <= 1'b0;
            m_fail   <= 1'b0;
        end else if (m_active) begin
            age   = m_age + 1;
            m_age <= age;
            if (age > WARMUP) begin
                idx  = age - WARMUP - 1;
                mism = (y_1 !== y_2);
                cnt  = m_cnt + (mism ? 1 : 0);
                if (mism) begin
                    m_cnt <= (cnt > 65535) ? 65535 : cnt;
                    if (m_cnt == 0) begin
                        m_ffc  <= 16'(idx);
                        m_diff <= y_1 ^ y_2;
                    end
                end
                if ((idx == MAX_CYCLES - 1) || (STOP_EN && mism)) begin
                    m_active <= 1'b0;
                    m_pass   <= (cnt == 0);
                    m_fail   <= (cnt != 0);
                end
            end
        end
    end

    // ---------------- scoreboard: per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("cyc_busy",  busy,             m_active);
            check("cyc_done",  done,             m_pass | m_fail);
            check("cyc_pass",  pass,             m_pass);
            check("cyc_fail",  fail,             m_fail);
            check("cyc_count", mismatch_count,   16'(m_cnt));
            check("cyc_ffc",   first_fail_cycle, m_ffc);
            check("cyc_diff",  first_diff,       m_diff);
        end
    end

    // ---------------- driver ----------------
    logic [WIDTH-1:0] diff_tab [RUN_EDGES];
    logic             busy_at  [RUN_EDGES+1];
    logic             fail_at  [RUN_EDGES+1];
    int               busy_cycles;

    task automatic clear_tab();
        for (int i = 0; i < RUN_EDGES; i++) diff_tab[i] = '0;
    endtask

    // diff_tab[a-1] is applied to y_2 for the a-th edge after the start edge;
    // busy_at/fail_at[a] record the outputs in the cycle after that edge.
    task automatic run(input logic [WIDTH-1:0] base, input int abort_age);
        busy_cycles = 0;
        @(negedge clk);
        start = 1'b1;
        y_1   = base;
        y_2   = base;
        for (int a = 1; a <= RUN_EDGES; a++) begin
            @(negedge clk);
            busy_at[a-1] = busy;
            fail_at[a-1] = fail;
            if (busy) busy_cycles++;
            start = 1'b0;
            abort = (a == abort_age);
            y_2   = base ^ diff_tab[a-1];
        end
        @(negedge clk);
        busy_at[RUN_EDGES] = busy;
        fail_at[RUN_EDGES] = fail;
        if (busy) busy_cycles++;
        abort = 1'b0;
        y_2   = base;
    endtask

    localparam logic [WIDTH-1:0] BASE_A = 91'h5A;
    localparam logic [WIDTH-1:0] BASE_B = 91'h3_1234_5678_9ABC_DEF0_1357;
    localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, 90'b0};

    initial begin
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        check("rst_busy",  busy,             0);
        check("rst_done",  done,             0);
        check("rst_pass",  pass,             0);
        check("rst_fail",  fail,             0);
        check("rst_count", mismatch_count,   0);
        check("rst_ffc",   first_fail_cycle, 0);
        check("rst_diff",  first_diff,       0);

        // equal outputs
        clear_tab();
        run(BASE_A, 0);
        check("eq_busy_cycles", busy_cycles,    10);
        check("eq_pass",        pass,           1);
        check("eq_done",        done,           1);
        check("eq_fail",        fail,           0);
        check("eq_count",       mismatch_count, 0);

        // single mismatch at CHECK index 3
        clear_tab();
        diff_tab[WARMUP+3] = 91'h1;
        run(BASE_B, 0);
        check("single_fail",  fail,             1);
        check("single_pass",  pass,             0);
        check("single_count", mismatch_count,   1);
        check("single_ffc",   first_fail_cycle, 3);
        check("single_diff",  first_diff,       91'h1);

        // mismatches only during warm-up
        clear_tab();
        diff_tab[0] = 91'hFF;
        diff_tab[1] = TOP_BIT;
        run(BASE_A, 0);
        check("warm_pass",  pass,           1);
        check("warm_count", mismatch_count, 0);

        // mismatches at CHECK indices 1, 4 and 6
        clear_tab();
        diff_tab[WARMUP+1] = 91'h8;
        diff_tab[WARMUP+4] = 91'h30;
        diff_tab[WARMUP+6] = TOP_BIT;
        run(BASE_B, 0);
        check("multi_fail", fail,             1);
        check("multi_ffc",  first_fail_cycle, 1);
        check("multi_diff", first_diff,       91'h8);
        check("multi_fail_before_idx1", fail_at[WARMUP+1], 0);
        if (STOP_EN) begin
            check("multi_count",      mismatch_count,    1);
            check("multi_fail_early", fail_at[WARMUP+2], 1);
        end else begin
            check("multi_count",     mismatch_count,          3);
            check("multi_busy_late", busy_at[RUN_EDGES-1],    1);
        end

        // abort at CHECK index 2, then a clean restart
        clear_tab();
        run(BASE_A, WARMUP + 3);
        check("abort_busy_after", busy_at[WARMUP+3], 0);
        check("abort_done",       done,              0);
        check("abort_pass",       pass,              0);
        check("abort_fail",       fail,              0);
        run(BASE_A, 0);
        check("restart_pass",  pass,           1);
        check("restart_count", mismatch_count, 0);

        // async reset during CHECK after one recorded mismatch
        @(negedge clk);
        start = 1'b1;
        y_1   = BASE_B;
        y_2   = BASE_B;
        @(negedge clk);
        start = 1'b0;
        repeat (WARMUP) @(negedge clk);
        y_2 = BASE_B ^ 91'h4;
        @(negedge clk);
        y_2 = BASE_B;
        check("pre_rst_count", mismatch_count, 1);
        check("pre_rst_busy",  busy,           1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",  busy,             0);
        check("arst_done",  done,             0);
        check("arst_count", mismatch_count,   0);
        check("arst_ffc",   first_fail_cycle, 0);
        check("arst_diff",  first_diff,       0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run(BASE_B, 0);
        check("post_rst_pass",  pass,           1);
        check("post_rst_count", mismatch_count, 0);

        cmp_en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
